// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ sample packetizer.
package daq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    // Header words are tagged with the bitwise complement of the data tag.
    function automatic logic [31:0] hdr_tag(input logic [31:0] user_tag);
        return ~user_tag;
    endfunction

endpackage

// File: rtl/daq_sample_buf.sv
// Small synchronous FIFO absorbing stream backpressure; a push into a full
// buffer is accepted when a pop happens in the same cycle.
module daq_sample_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/daq_axis_packetizer.sv
// Packs two-channel ADC samples into fixed-length AXI-stream packets.
// Define DAQ_PKT_HEADER_EN to prefix each packet with a header word.
module daq_axis_packetizer
    import daq_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                USER_W    = 8,
    parameter int                SMP_W     = 16,
    parameter int                PKT_LEN   = 64,
    parameter int                BUF_DEPTH = 4,
    parameter logic [USER_W-1:0] USER_TAG  = 8'hAA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [SMP_W-1:0]  ch0_sample,
    input  logic [SMP_W-1:0]  ch1_sample,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [USER_W-1:0] m_tuser,
    output logic [15:0]       drop_count,
    output logic [15:0]       pkt_count,
    output logic              busy
);

    localparam int                WCNT_W    = $clog2(PKT_LEN);
    localparam int                CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_LEN - 1);
    localparam logic [USER_W-1:0] HDR_USER  = USER_W'(hdr_tag(32'(USER_TAG)));

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == DROP_SAT) ? v : v + 16'd1;
    endfunction

    state_t            state;
    logic [WCNT_W-1:0] word_cnt;
    logic [DATA_W-1:0] buf_din;
    logic [DATA_W-1:0] buf_dout;
    logic              buf_full;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              data_vld;
    logic              hdr_vld;
    logic              at_last;
    logic              more_after_pop;

`ifdef DAQ_PKT_HEADER_EN
    localparam state_t START_ST = HDR;
    assign hdr_vld = (state == HDR);
`else
    localparam state_t START_ST = DATA;
    assign hdr_vld = 1'b0;
`endif

    assign buf_din        = {ch1_sample, ch0_sample};
    assign push_req       = sample_valid && ((state != IDLE) || en);
    assign data_vld       = (state == DATA) && !buf_empty;
    assign pop            = data_vld && m_tready;
    assign push           = push_req && (!buf_full || pop);
    assign drop           = push_req && buf_full && !pop;
    assign at_last        = (word_cnt == LAST_WORD);
    // Only consulted on a popping transfer, so the buffer holds at least one entry.
    assign more_after_pop = (buf_count > CNT_W'(1)) || push;

    daq_sample_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (buf_din),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // Outputs are decoded from registered state and buffer pointers only,
    // so tvalid never depends on tready and the head word stays put until popped.
    assign m_tvalid = data_vld || hdr_vld;
    assign m_tlast  = data_vld && at_last;
    assign busy     = (state != IDLE);

    always_comb begin
        m_tdata = '0;
        m_tuser = '0;
        if (data_vld) begin
            m_tdata = buf_dout;
            m_tuser = USER_TAG;
        end else if (hdr_vld) begin
            m_tdata = DATA_W'({pkt_count, 16'(PKT_LEN)});
            m_tuser = HDR_USER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_cnt   <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (drop) drop_count <= sat_inc(drop_count);
            case (state)
                IDLE: begin
                    if (en && !buf_empty) state <= START_ST;
                end
                HDR: begin
                    if (m_tready) state <= DATA;
                end
                DATA: begin
                    if (pop) begin
                        if (at_last) begin
                            word_cnt  <= '0;
                            pkt_count <= pkt_count + 16'd1;
                            state     <= (en && more_after_pop) ? START_ST : IDLE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/daq_axis_packetizer.md
Name: daq_axis_packetizer

Overview:
- Source end of the DAQ sample stream: packs free-running two-channel ADC samples into AXI-stream words and frames them into fixed-length packets for the downstream axi_fifo slave port.
- The ADC side cannot stall. A small internal buffer absorbs stream backpressure; samples that arrive with the buffer full are dropped and counted.
- Sits between the ADC capture logic and axi_fifo.

Parameters:
- DATA_W, 32, stream data width; must equal 2*SMP_W.
- USER_W, 8, tuser width.
- SMP_W, 16, per-channel sample width.
- PKT_LEN, 64, data words per packet (>=2).
- BUF_DEPTH, 4, sample buffer entries (power of 2, >=2).
- USER_TAG, 8'hAA, tuser value on data words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable, sampled only at packet start.
- sample_valid  in  1  one-cycle strobe, new sample pair present.
- ch0_sample  in  SMP_W  channel 0 sample.
- ch1_sample  in  SMP_W  channel 1 sample.
- m_tdata  out  DATA_W  {ch1, ch0}.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last word of packet.
- m_tuser  out  USER_W  word tag.
- drop_count  out  16  samples lost to full buffer; saturates at 16'hFFFF.
- pkt_count  out  16  completed packets; wraps.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, buffer empty. m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, drop_count=0, pkt_count=0, busy=0.
- Buffer push:
  - Occurs on sample_valid when the block is capturing, i.e. state != IDLE, or state IDLE with en=1.
  - sample_valid in IDLE with en=0 is discarded silently and is not counted.
- Full buffer:
  - Full with a pop in the same cycle: the push is accepted.
  - Full with no pop: the sample is dropped and drop_count increments, saturating.
- Handshake:
  - Transfer occurs when m_tvalid && m_tready.
  - Once asserted, m_tvalid holds until the transfer, and tdata/tlast/tuser stay stable.
  - m_tvalid never depends combinationally on m_tready.
- Latency: a sample strobed at cycle N can appear on m_tdata at N+1 at the earliest (buffer write is registered; output comes from the buffer head).
- FSM transitions:
  - IDLE -> DATA when en=1 and the buffer is non-empty.
  - DATA: m_tvalid = buffer non-empty. Each transfer pops the buffer and increments word_cnt (0..PKT_LEN-1).
  - m_tlast=1 exactly when word_cnt==PKT_LEN-1.
  - A transfer with tlast: pkt_count++, word_cnt=0. Go to DATA if en=1 and the buffer is non-empty after the pop, otherwise IDLE. Back-to-back packets therefore need no bubble.
- en deassert mid-packet: the packet always completes to PKT_LEN words; samples keep being accepted until tlast transfers. No truncated packets are ever emitted.
- Data words carry m_tuser=USER_TAG.
- word_cnt width: $clog2(PKT_LEN). Buffer pointers: $clog2(BUF_DEPTH)+1 bits.

Optional Feature:
- Macro DAQ_PKT_HEADER_EN.
- Defined:
  - Adds a HDR state. IDLE -> HDR (same condition as IDLE -> DATA above).
  - HDR drives m_tvalid=1, m_tdata={pkt_count, PKT_LEN[15:0]}, m_tuser=~USER_TAG (8'h55 by default), m_tlast=0, and does not pop the buffer.
  - On the header transfer, HDR -> DATA.
  - The packet restart after tlast also passes through HDR.
- Undefined: no HDR state; packets are PKT_LEN data words only.

Decomposition:
- daq_pkg holds:
  - state enum (IDLE, HDR, DATA);
  - HDR_TAG function (~USER_TAG);
  - the DROP_SAT constant 16'hFFFF.
- Sub-module daq_sample_buf: BUF_DEPTH-entry synchronous FIFO, push/pop/full/empty, same-cycle push+pop allowed when full. The packetizer instantiates it once.

Test Plan:
- en=1, m_tready=1, 130 strobes, ch0=0..129, ch1=1..130, PKT_LEN=64 -> 130 words {ch1,ch0} in order; tlast on words 63 and 127; tuser=8'hAA; pkt_count=2; drop_count=0.
- Random m_tready (50%), random sample_valid, 5000 cycles -> scoreboard (sent minus dropped) matches in order; tdata/tlast/tuser never change while tvalid && !tready.
- m_tready=0, 10 consecutive strobes, BUF_DEPTH=4 -> drop_count=6, tvalid held with data of sample 0; after ready, exactly samples 0..3 emerge.
- en dropped after word 10 of a packet, strobes continue -> packet completes with 64 words then IDLE; busy=0; later strobes ignored; drop_count unchanged.
- rst_n asserted mid-packet with tvalid high -> all outputs 0 immediately (async); after release, the next packet starts with word_cnt=0 and pkt_count=0.
- DAQ_PKT_HEADER_EN defined, two packets -> headers 32'h0000_0040 then 32'h0001_0040 with tuser=8'h55, each followed by 64 data words.
